// File: rtl/reg_file_pkg.sv
// rtl/reg_file_pkg.sv - register file request/response types and sizing constants
package reg_file_pkg;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int AW    = $clog2(NREGS);

    typedef struct packed {
        logic          en;
        logic [AW-1:0] addr;
    } rf_read_req_t;

    typedef struct packed {
        logic [XLEN-1:0] value;
        logic            busy;
    } rf_read_rsp_t;

    typedef struct packed {
        logic            en;
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] value;
    } rf_write_req_t;

    typedef struct packed {
        logic          en;
        logic [AW-1:0] addr;
    } rf_rsv_req_t;

endpackage

// File: rtl/reg_file_if.sv
// rtl/reg_file_if.sv - read, writeback and reserve bundle between pipeline stages and the register file
interface reg_file_if;
    import reg_file_pkg::*;

    rf_read_req_t  rs1_rf_read_req;
    rf_read_req_t  rs2_rf_read_req;
    rf_read_rsp_t  rs1_rf_read_rsp;
    rf_read_rsp_t  rs2_rf_read_rsp;
    rf_write_req_t rf_write_req;
    rf_rsv_req_t   rf_rsv_req;

    modport master (
        output rs1_rf_read_req, rs2_rf_read_req, rf_write_req, rf_rsv_req,
        input  rs1_rf_read_rsp, rs2_rf_read_rsp
    );

    modport slave (
        input  rs1_rf_read_req, rs2_rf_read_req, rf_write_req, rf_rsv_req,
        output rs1_rf_read_rsp, rs2_rf_read_rsp
    );

endinterface

// File: rtl/rf_scoreboard.sv
// rtl/rf_scoreboard.sv - per-register busy bits, cleared by writeback and set by reserve
module rf_scoreboard
    import reg_file_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_en,
    input  logic [AW-1:0]    clr_addr,
    input  logic             set_en,
    input  logic [AW-1:0]    set_addr,
    output logic [NREGS-1:1] busy
);

    // Set is applied after clear so a same-cycle reserve from a newer producer wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= '0;
        end else begin
            if (clr_en && clr_addr != '0) busy[clr_addr] <= 1'b0;
            if (set_en && set_addr != '0) busy[set_addr] <= 1'b1;
        end
    end

endmodule

// File: rtl/reg_file.sv
// rtl/reg_file.sv - integer register file with busy scoreboard; REG_FILE_BYPASS_EN forwards same-cycle writeback
module reg_file
    import reg_file_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    reg_file_if.slave  rf
);

    logic [XLEN-1:0]  regs [1:NREGS-1];
    logic [NREGS-1:1] sb;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 1; i < NREGS; i++) regs[i] <= '0;
        end else if (rf.rf_write_req.en && rf.rf_write_req.addr != '0) begin
            regs[rf.rf_write_req.addr] <= rf.rf_write_req.value;
        end
    end

    rf_scoreboard u_sb (
        .clk      (clk),
        .rst      (rst),
        .clr_en   (rf.rf_write_req.en),
        .clr_addr (rf.rf_write_req.addr),
        .set_en   (rf.rf_rsv_req.en),
        .set_addr (rf.rf_rsv_req.addr),
        .busy     (sb)
    );

    function automatic rf_read_rsp_t read_port(rf_read_req_t req);
        rf_read_rsp_t rsp;
        rsp = '0;
        if (req.en && req.addr != '0) begin
            rsp.value = regs[req.addr];
            rsp.busy  = sb[req.addr];
`ifdef REG_FILE_BYPASS_EN
            // Busy mirrors what the scoreboard will hold after this edge.
            if (rf.rf_write_req.en && rf.rf_write_req.addr == req.addr) begin
                rsp.value = rf.rf_write_req.value;
                rsp.busy  = rf.rf_rsv_req.en && rf.rf_rsv_req.addr == req.addr;
            end
`endif
        end
        return rsp;
    endfunction

    always_comb begin
        rf.rs1_rf_read_rsp = read_port(rf.rs1_rf_read_req);
        rf.rs2_rf_read_rsp = read_port(rf.rs2_rf_read_req);
    end

endmodule
